// File: rtl/dct_transpose_ctrl.sv
// Ping-pong transpose controller between the row and column DCT stages.
// Blocks are written row-major into one RAM bank and read back column-major from the other.
module dct_transpose_ctrl #(
    parameter int DataWidth = 16,
    parameter int Log2N     = 3,
    parameter int AddrWidth = 9
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [DataWidth-1:0] s_data_i,
    input  logic                 s_valid_i,
    output logic                 s_ready_o,
    output logic [DataWidth-1:0] m_data_o,
    output logic                 m_valid_o,
    input  logic                 m_ready_i,
    output logic                 m_last_o,
    output logic [AddrWidth-1:0] addra_o,
    output logic                 ena_o,
    output logic                 wea_o,
    output logic [DataWidth-1:0] dina_o,
    output logic [AddrWidth-1:0] addrb_o,
    output logic                 enb_o,
    input  logic [DataWidth-1:0] doutb_i
);
    localparam int CntW = 2 * Log2N;
    localparam logic [CntW-1:0] CntMax = '1;
    localparam logic [CntW-1:0] CntOne = 1;

    logic [1:0]           full_q, full_d;
    logic                 wr_bank_q, wr_bank_d;
    logic [CntW-1:0]      wr_cnt_q, wr_cnt_d;
    logic                 rd_bank_q, rd_bank_d;
    logic [CntW-1:0]      rd_cnt_q, rd_cnt_d;
    logic                 inflight_q, inflight_d;
    logic                 inflight_last_q, inflight_last_d;
    logic [DataWidth-1:0] fifo_data_q [2];
    logic [DataWidth-1:0] fifo_data_d [2];
    logic [1:0]           fifo_last_q, fifo_last_d;
    logic                 fifo_rd_ptr_q, fifo_rd_ptr_d;
    logic                 fifo_wr_ptr_q, fifo_wr_ptr_d;
    logic [1:0]           fifo_occ_q, fifo_occ_d;

    logic       wr_hs;
    logic       pop;
    logic       push;
    logic       issue;
    logic [2:0] fifo_demand;
    logic [2:0] fifo_limit;

    // Valid/ready: a transfer happens on a rising clk edge where valid and ready are both 1;
    // s_ready_o and m_valid_o never depend combinationally on the partner's valid/ready.
    assign wr_hs       = s_valid_i && s_ready_o;
    assign pop         = m_valid_o && m_ready_i;
    assign push        = inflight_q;
    // A read may only issue if its data is guaranteed a FIFO slot when it returns.
    assign fifo_demand = {1'b0, fifo_occ_q} + {2'b00, inflight_q};
    assign fifo_limit  = 3'd2 + {2'b00, pop};
    assign issue       = !rst_i && full_q[rd_bank_q] && (fifo_demand < fifo_limit);

    assign s_ready_o = !rst_i && !full_q[wr_bank_q];
    assign ena_o     = wr_hs;
    assign wea_o     = wr_hs;
    assign dina_o    = rst_i ? '0 : s_data_i;
    assign addra_o   = rst_i ? '0 : AddrWidth'({wr_bank_q, wr_cnt_q});
    assign enb_o     = issue;
    // Low counter bits select the row, so consecutive reads walk down a column.
    assign addrb_o   = rst_i ? '0 :
                       AddrWidth'({rd_bank_q, rd_cnt_q[Log2N-1:0], rd_cnt_q[CntW-1:Log2N]});
    assign m_valid_o = !rst_i && (fifo_occ_q != 2'd0);
    assign m_data_o  = m_valid_o ? fifo_data_q[fifo_rd_ptr_q] : '0;
    assign m_last_o  = m_valid_o && fifo_last_q[fifo_rd_ptr_q];

    always_comb begin
        full_d          = full_q;
        wr_bank_d       = wr_bank_q;
        wr_cnt_d        = wr_cnt_q;
        rd_bank_d       = rd_bank_q;
        rd_cnt_d        = rd_cnt_q;
        inflight_d      = issue;
        inflight_last_d = issue && (rd_cnt_q == CntMax);
        fifo_data_d     = fifo_data_q;
        fifo_last_d     = fifo_last_q;
        fifo_rd_ptr_d   = fifo_rd_ptr_q;
        fifo_wr_ptr_d   = fifo_wr_ptr_q;
        fifo_occ_d      = fifo_occ_q;

        if (wr_hs) begin
            wr_cnt_d = wr_cnt_q + CntOne;
            if (wr_cnt_q == CntMax) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = !wr_bank_q;
            end
        end

        // The write bank is never full and the read bank always is, so these never collide.
        if (issue) begin
            rd_cnt_d = rd_cnt_q + CntOne;
            if (rd_cnt_q == CntMax) begin
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = !rd_bank_q;
            end
        end

        if (push) begin
            fifo_data_d[fifo_wr_ptr_q] = doutb_i;
            fifo_last_d[fifo_wr_ptr_q] = inflight_last_q;
            fifo_wr_ptr_d              = !fifo_wr_ptr_q;
        end
        if (pop) begin
            fifo_rd_ptr_d = !fifo_rd_ptr_q;
        end
        fifo_occ_d = fifo_occ_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            full_q          <= '0;
            wr_bank_q       <= 1'b0;
            wr_cnt_q        <= '0;
            rd_bank_q       <= 1'b0;
            rd_cnt_q        <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            fifo_data_q[0]  <= '0;
            fifo_data_q[1]  <= '0;
            fifo_last_q     <= '0;
            fifo_rd_ptr_q   <= 1'b0;
            fifo_wr_ptr_q   <= 1'b0;
            fifo_occ_q      <= '0;
        end else begin
            full_q          <= full_d;
            wr_bank_q       <= wr_bank_d;
            wr_cnt_q        <= wr_cnt_d;
            rd_bank_q       <= rd_bank_d;
            rd_cnt_q        <= rd_cnt_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            fifo_data_q     <= fifo_data_d;
            fifo_last_q     <= fifo_last_d;
            fifo_rd_ptr_q   <= fifo_rd_ptr_d;
            fifo_wr_ptr_q   <= fifo_wr_ptr_d;
            fifo_occ_q      <= fifo_occ_d;
        end
    end
endmodule

// File: tb/tb_dct_transpose_ctrl.sv
// Bench for dct_transpose_ctrl: an 8x8 instance with a behavioural dual-port RAM and
// a transposed-order scoreboard, plus a 4x4 instance for the small-block case.
module tb_dct_transpose_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [15:0] m_data;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic        m_last;
    logic [8:0]  addra, addrb;
    logic        ena, wea, enb;
    logic [15:0] dina;
    logic [15:0] doutb = '0;
    logic [15:0] mem8 [512];

    logic [15:0] s4_data = '0;
    logic        s4_valid = 1'b0;
    logic        s4_ready;
    logic [15:0] m4_data;
    logic        m4_valid;
    logic        m4_ready = 1'b1;
    logic        m4_last;
    logic [8:0]  addra4, addrb4;
    logic        ena4, wea4, enb4;
    logic [15:0] dina4;
    logic [15:0] doutb4 = '0;
    logic [15:0] mem4 [512];

    always #5 clk = ~clk;

    dct_transpose_ctrl #(.DataWidth(16), .Log2N(3), .AddrWidth(9)) dut (
        .clk_i(clk), .rst_i(rst), .s_data_i(s_data), .s_valid_i(s_valid), .s_ready_o(s_ready),
        .m_data_o(m_data), .m_valid_o(m_valid), .m_ready_i(m_ready), .m_last_o(m_last),
        .addra_o(addra), .ena_o(ena), .wea_o(wea), .dina_o(dina),
        .addrb_o(addrb), .enb_o(enb), .doutb_i(doutb)
    );

    dct_transpose_ctrl #(.DataWidth(16), .Log2N(2), .AddrWidth(9)) dut4 (
        .clk_i(clk), .rst_i(rst), .s_data_i(s4_data), .s_valid_i(s4_valid), .s_ready_o(s4_ready),
        .m_data_o(m4_data), .m_valid_o(m4_valid), .m_ready_i(m4_ready), .m_last_o(m4_last),
        .addra_o(addra4), .ena_o(ena4), .wea_o(wea4), .dina_o(dina4),
        .addrb_o(addrb4), .enb_o(enb4), .doutb_i(doutb4)
    );

    always @(posedge clk) begin
        if (ena && wea) mem8[addra] <= dina;
        if (enb) doutb <= mem8[addrb];
        if (ena4 && wea4) mem4[addra4] <= dina4;
        if (enb4) doutb4 <= mem4[addrb4];
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rpct = 0;
    int hs_cyc, stall_cnt, pops, pop_first, pop_last, first_valid_cyc, iss0_cnt, iss0_cyc;
    bit seen_valid, stall_pend;
    logic [16:0] stall_val;
    logic [16:0] exp_q[$];
    logic [15:0] cur_blk [64];

    typedef struct {
        int nblk;
        int vpct;
        int rpct;
        int exp_pops;
    } scen_t;
    scen_t scen [3];

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        m_ready = ($urandom_range(99) < rpct);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Scoreboard: pop on every accepted output, and require held data while stalled.
    always @(negedge clk) begin
        logic [16:0] e;
        if (rst) begin
            stall_pend = 1'b0;
        end else begin
            if (enb && !addrb[6]) begin
                iss0_cnt++;
                if (iss0_cnt == 64) iss0_cyc = cyc;
            end
            if (ena4) chk("addra4_upper", {28'd0, addra4[8:5]}, 32'd0);
            if (enb4) chk("addrb4_upper", {28'd0, addrb4[8:5]}, 32'd0);
            if (m_valid) begin
                if (!seen_valid) begin
                    seen_valid = 1'b1;
                    first_valid_cyc = cyc;
                end
                if (stall_pend) chk("hold_stable", {15'd0, m_last, m_data}, {15'd0, stall_val});
                if (m_ready) begin
                    if (exp_q.size() == 0) begin
                        fail_now("unexpected_output");
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_data", {16'd0, m_data}, {16'd0, e[15:0]});
                        chk("out_last", {31'd0, m_last}, {31'd0, e[16]});
                    end
                    pops++;
                    if (pops == 1) pop_first = cyc;
                    pop_last = cyc;
                    stall_pend = 1'b0;
                end else begin
                    stall_pend = 1'b1;
                    stall_val = {m_last, m_data};
                end
            end else if (stall_pend) begin
                fail_now("valid_dropped_while_stalled");
                stall_pend = 1'b0;
            end
        end
    end

    task automatic send_sample(input logic [15:0] d, input int vpct);
        int waits;
        logic ok;
        while ($urandom_range(99) >= vpct) begin
            s_valid = 1'b0;
            @(posedge clk); #1;
        end
        s_valid = 1'b1;
        s_data = d;
        waits = 0;
        forever begin
            @(negedge clk);
            ok = s_ready;
            if (ok) hs_cyc = cyc;
            else stall_cnt++;
            @(posedge clk); #1;
            if (ok) break;
            waits++;
            if (waits > 2000) begin
                fail_now("send_timeout");
                break;
            end
        end
        s_valid = 1'b0;
    endtask

    task automatic fill_block(input int base, input bit rnd);
        for (int i = 0; i < 64; i++) cur_blk[i] = rnd ? 16'($urandom_range(65535)) : 16'(base + i);
        for (int c = 0; c < 8; c++)
            for (int r = 0; r < 8; r++)
                exp_q.push_back({(c == 7 && r == 7), cur_blk[r * 8 + c]});
    endtask

    task automatic send_block(input int base, input bit rnd, input int vpct);
        fill_block(base, rnd);
        for (int i = 0; i < 64; i++) send_sample(cur_blk[i], vpct);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        if (exp_q.size() != 0) fail_now(name);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string name);
        @(negedge clk);
        chk({name, "_s_ready"}, {31'd0, s_ready}, 32'd0);
        chk({name, "_m_valid"}, {31'd0, m_valid}, 32'd0);
        chk({name, "_m_last"}, {31'd0, m_last}, 32'd0);
        chk({name, "_m_data"}, {16'd0, m_data}, 32'd0);
        chk({name, "_ena_wea_enb"}, {29'd0, ena, wea, enb}, 32'd0);
        chk({name, "_addra"}, {23'd0, addra}, 32'd0);
        chk({name, "_addrb"}, {23'd0, addrb}, 32'd0);
        chk({name, "_dina"}, {16'd0, dina}, 32'd0);
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        s_valid = 1'b1;
        s_data = 16'hbeef;
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        s_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("post_reset_s_ready", {31'd0, s_ready}, 32'd1);
        chk("post_reset_m_valid", {31'd0, m_valid}, 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        int rise_cyc, k, n;
        scen[0] = '{nblk: 10, vpct: 50, rpct: 50, exp_pops: 640};
        scen[1] = '{nblk: 2, vpct: 100, rpct: 30, exp_pops: 128};
        scen[2] = '{nblk: 2, vpct: 70, rpct: 100, exp_pops: 128};

        s_valid = 1'b1;
        s_data = 16'h1234;
        check_reset_outputs("init_reset");
        repeat (2) @(posedge clk);
        apply_reset();

        // Single block: transposed order and three-cycle latency.
        rpct = 100;
        seen_valid = 1'b0;
        send_block(0, 1'b0, 100);
        drain("single_block_drain");
        chk("latency", 32'(first_valid_cyc - hs_cyc), 32'd3);

        // Two back-to-back blocks with no input stall and no output gap.
        pops = 0;
        stall_cnt = 0;
        send_block(0, 1'b0, 100);
        send_block(100, 1'b0, 100);
        drain("two_block_drain");
        chk("two_block_stalls", 32'(stall_cnt), 32'd0);
        chk("two_block_pops", 32'(pops), 32'd128);
        chk("two_block_no_gap", 32'(pop_last - pop_first), 32'd127);

        // Both banks full: input stalls until the 64th bank-0 read issues.
        apply_reset();
        rpct = 0;
        iss0_cnt = 0;
        stall_cnt = 0;
        send_block(1000, 1'b0, 100);
        send_block(2000, 1'b0, 100);
        chk("bp_first_128_stalls", 32'(stall_cnt), 32'd0);
        fill_block(3000, 1'b0);
        s_valid = 1'b1;
        s_data = cur_blk[0];
        repeat (5) begin
            @(negedge clk);
            chk("bp_ready_low", {31'd0, s_ready}, 32'd0);
        end
        @(posedge clk); #1;
        rpct = 100;
        rise_cyc = -1;
        n = 0;
        while (n < 400) begin
            @(negedge clk);
            if (s_ready) begin
                rise_cyc = cyc;
                break;
            end
            n++;
        end
        if (rise_cyc < 0) fail_now("bp_ready_never_rose");
        else chk("bp_ready_rise", 32'(rise_cyc), 32'(iss0_cyc + 1));
        @(posedge clk); #1;
        s_valid = 1'b0;
        for (int i = 1; i < 64; i++) send_sample(cur_blk[i], 100);
        drain("bp_drain");

        // Randomised scenarios from the table.
        for (int t = 0; t < 3; t++) begin
            rpct = scen[t].rpct;
            pops = 0;
            for (int b = 0; b < scen[t].nblk; b++) send_block(0, 1'b1, scen[t].vpct);
            drain("rand_drain");
            chk("rand_pop_count", 32'(pops), 32'(scen[t].exp_pops));
        end

        // Reset mid-operation with output pending and a partial block written.
        rpct = 0;
        send_block(0, 1'b1, 100);
        for (int i = 0; i < 37; i++) send_sample(16'($urandom_range(65535)), 100);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("pending_before_reset", {31'd0, m_valid}, 32'd1);
        apply_reset();
        rpct = 100;
        pops = 0;
        send_block(0, 1'b0, 100);
        drain("after_reset_drain");
        chk("after_reset_pops", 32'(pops), 32'd64);

        // 4x4 instance.
        k = 0;
        fork
            begin
                for (int i = 0; i < 16; i++) begin
                    s4_valid = 1'b1;
                    s4_data = 16'(i);
                    n = 0;
                    do begin
                        @(negedge clk);
                        n++;
                    end while (!s4_ready && n < 100);
                    @(posedge clk); #1;
                end
                s4_valid = 1'b0;
            end
            begin
                for (int c = 0; c < 200 && k < 16; c++) begin
                    @(negedge clk);
                    if (m4_valid) begin
                        chk("t4_data", {16'd0, m4_data}, 32'((k % 4) * 4 + k / 4));
                        chk("t4_last", {31'd0, m4_last}, {31'd0, (k == 15)});
                        k++;
                    end
                end
            end
        join
        chk("t4_count", 32'(k), 32'd16);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
